fc_classifier_fx: RTL and testbench
===================================

Name: fc_classifier_fx

Overview:
- Parametrised fixed-point fully-connected classifier layer: computes score[j] = bias[j] + sum_i x[i]*w[i][j] for N_CLS classes, then returns the argmax class.
- Operands are loaded over a single valid/ready stream.
- One shared multiply-accumulate datapath, one product per cycle.
- Sits after the feature-extraction stage; its class result drives the decision/display logic.

Parameters:
- N_IN, 3, number of input features.
- N_CLS, 2, number of classes (>=2).
- DATA_W, 16, width of features, weights, biases and scores (signed two's complement).
- FRAC_W, 8, fractional bits of the Q format shared by all DATA_W quantities.
- ACC_W, 40, accumulator width; must be >= 2*DATA_W + clog2(N_IN) + 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a new inference; sampled only in IDLE.
- in_valid  in  1  in_data valid.
- in_data  in  DATA_W  feature/weight/bias word.
- in_ready  out  1  high only in LOAD.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a result is ready.
- class_idx  out  max(1,clog2(N_CLS))  winning class, binary.
- class_onehot  out  N_CLS  bit j set means class j wins (LSB = class 0).
- max_score  out  DATA_W  saturated score of the winning class.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, in_ready, class_idx, class_onehot and max_score all 0. Operand memories are not cleared, and reset mid-run discards the run.
- Opening a run: IDLE + start moves to LOAD on the next edge. start is ignored in all other states.
- LOAD stream order, accepted one word per edge with in_valid && in_ready:
  - N_IN features x[0..N_IN-1];
  - then N_IN*N_CLS weights, feature-major: position i*N_CLS+j holds w[i][j];
  - then N_CLS biases b[0..N_CLS-1].
- Load length: L = N_IN*(N_CLS+1) + N_CLS words total. in_valid gaps stall the load without penalty. in_valid while in_ready=0 is ignored.
- Transition to MAC: the edge that accepts word L-1 enters MAC.
- MAC: N_IN*N_CLS cycles, class outer loop j, feature inner loop i.
  - acc += sign-extended (x[i]*w[i][j]); the full 2*DATA_W product carries 2*FRAC_W fraction bits.
  - acc is cleared at i=0 of each class.
  - At i=N_IN-1 the class score is formed and stored in a score register file:
    - t = acc + (b[j] sign-extended, << FRAC_W);
    - score[j] = t >>> FRAC_W (arithmetic, truncate toward -inf);
    - saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - The accumulator itself never saturates; sizing via ACC_W prevents overflow.
- ARGMAX: N_CLS cycles, scanning j=0..N_CLS-1.
  - Class 0 is always taken as the initial best.
  - A later class replaces the best only if strictly greater (signed). Ties keep the lowest index.
- DONE entry: the final ARGMAX edge registers class_idx, class_onehot and max_score, and enters DONE.
  - done=1 for exactly that one DONE cycle; the next edge returns to IDLE.
  - done therefore first appears N_IN*N_CLS + N_CLS edges after the edge accepting the last word.
- Result hold: class_idx, class_onehot and max_score hold their values through IDLE and through the next run's LOAD/MAC/ARGMAX. They change only at the next DONE entry or on reset.
- Back-to-back runs: start asserted in the IDLE cycle right after DONE begins a new run. All operands must be reloaded.
- Out-of-range counters: must be unreachable. Any illegal state encoding goes to IDLE.

Test Plan:
- Nominal scores (N_IN=3, N_CLS=2, Q8.8):
  - Stimulus: x={0x0100,0x0200,0xFF00}; w stream {0x0100,0x0080,0x0080,0x0100,0x0100,0xFF00}; b={0x0040,0xFF80}.
  - Required: scores 1.25/3.0; class_idx=1, class_onehot=2'b10, max_score=0x0300.
  - Required: done exactly 8 edges after the last accepted word, pulse width 1.
- Tie: all weights 0, b={0x0100,0x0100} -> class_idx=0, onehot=2'b01, max_score=0x0100.
- Saturation:
  - x and w all 0x7FFF, biases 0 -> max_score=0x7FFF, class_idx=0.
  - w all 0x8000 -> both scores 0x8000, class_idx=0.
- Backpressure: nominal data with 1-3 cycle in_valid gaps, plus in_valid pulses while in IDLE/MAC.
  - Required: identical result; in_ready high only in LOAD; spurious words ignored.
- Protocol: start pulsed during LOAD and MAC is ignored (word count and result unchanged); start in IDLE right after done launches a second run with new data and a correct new result.
- Reset mid-MAC: reset asserted asynchronously between clock edges.
  - Required: busy/done/class_onehot/max_score read 0 before the next edge.
  - Required: a full reload then yields the nominal result.

Source files
------------

// File: rtl/fc_classifier_fx.sv
// Fixed-point fully-connected classifier layer with argmax output.
// Operands arrive on a valid/ready stream; one shared MAC evaluates a product per cycle.
module fc_classifier_fx #(
  parameter  int N_IN   = 3,
  parameter  int N_CLS  = 2,
  parameter  int DATA_W = 16,
  parameter  int FRAC_W = 8,
  parameter  int ACC_W  = 40,
  localparam int IDX_W  = (N_CLS > 1) ? $clog2(N_CLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  class_idx,
  output logic [N_CLS-1:0]  class_onehot,
  output logic [DATA_W-1:0] max_score
);

  localparam int LOAD_LEN = N_IN * (N_CLS + 1) + N_CLS;
  localparam int LOAD_W   = $clog2(LOAD_LEN);
  localparam int FEAT_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PROD_W   = 2 * DATA_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_MAC    = 3'd2;
  localparam logic [2:0] ST_ARGMAX = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [2:0]               state;
  logic [LOAD_W-1:0]        load_cnt;
  logic [FEAT_W-1:0]        feat_cnt;
  logic [IDX_W-1:0]         cls_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         best_idx;
  logic signed [DATA_W-1:0] best_score;

  logic signed [DATA_W-1:0] x_mem     [N_IN];
  logic signed [DATA_W-1:0] w_mem     [N_IN][N_CLS];
  logic signed [DATA_W-1:0] b_mem     [N_CLS];
  logic signed [DATA_W-1:0] score_mem [N_CLS];

  logic accept;
  logic last_word;
  logic last_feat;
  logic last_cls;

  assign accept    = in_valid && (state == ST_LOAD);
  assign last_word = (load_cnt == LOAD_W'(LOAD_LEN - 1));
  assign last_feat = (feat_cnt == FEAT_W'(N_IN - 1));
  assign last_cls  = (cls_cnt == IDX_W'(N_CLS - 1));

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // MAC datapath: accumulate the product, and on the last feature fold in the bias,
  // drop the extra fraction bits (floor) and clamp to the DATA_W range.
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  biased;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] score_sat;

  always_comb begin
    product  = PROD_W'(x_mem[feat_cnt]) * PROD_W'(w_mem[feat_cnt][cls_cnt]);
    acc_base = (feat_cnt == '0) ? SAT_MAX ^ SAT_MAX : acc;
    acc_sum  = acc_base + ACC_W'(product);
    biased   = acc_sum + (ACC_W'(b_mem[cls_cnt]) <<< FRAC_W);
    shifted  = biased >>> FRAC_W;
    if (shifted > SAT_MAX) begin
      score_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      score_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      score_sat = shifted[DATA_W-1:0];
    end
  end

  // Running argmax: class 0 seeds the search, later classes must be strictly larger.
  logic [IDX_W-1:0]         next_idx;
  logic signed [DATA_W-1:0] next_score;

  always_comb begin
    next_idx   = best_idx;
    next_score = best_score;
    if (cls_cnt == '0) begin
      next_idx   = '0;
      next_score = score_mem[0];
    end else if (score_mem[cls_cnt] > best_score) begin
      next_idx   = cls_cnt;
      next_score = score_mem[cls_cnt];
    end
  end

  // Operand and score storage survive reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_IN; i++) begin
        if (load_cnt == LOAD_W'(i)) x_mem[i] <= in_data;
      end
      for (int i = 0; i < N_IN; i++) begin
        for (int j = 0; j < N_CLS; j++) begin
          if (load_cnt == LOAD_W'(N_IN + i * N_CLS + j)) w_mem[i][j] <= in_data;
        end
      end
      for (int j = 0; j < N_CLS; j++) begin
        if (load_cnt == LOAD_W'(N_IN * (N_CLS + 1) + j)) b_mem[j] <= in_data;
      end
    end
    if (state == ST_MAC && last_feat) begin
      score_mem[cls_cnt] <= score_sat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      load_cnt     <= '0;
      feat_cnt     <= '0;
      cls_cnt      <= '0;
      acc          <= '0;
      best_idx     <= '0;
      best_score   <= '0;
      class_idx    <= '0;
      class_onehot <= '0;
      max_score    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            load_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (last_word) begin
              state    <= ST_MAC;
              load_cnt <= '0;
              feat_cnt <= '0;
              cls_cnt  <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        ST_MAC: begin
          acc <= acc_sum;
          if (last_feat) begin
            feat_cnt <= '0;
            if (last_cls) begin
              cls_cnt <= '0;
              state   <= ST_ARGMAX;
            end else begin
              cls_cnt <= cls_cnt + 1'b1;
            end
          end else begin
            feat_cnt <= feat_cnt + 1'b1;
          end
        end
        ST_ARGMAX: begin
          best_idx   <= next_idx;
          best_score <= next_score;
          if (last_cls) begin
            cls_cnt      <= '0;
            class_idx    <= next_idx;
            class_onehot <= {{(N_CLS-1){1'b0}}, 1'b1} << next_idx;
            max_score    <= next_score;
            state        <= ST_DONE;
          end else begin
            cls_cnt <= cls_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_classifier_fx.sv
// Self-checking bench for fc_classifier_fx: reference model of the full layer
// plus directed literal cases (nominal, tie, saturation, backpressure, reset).
module tb_fc_classifier_fx;

  localparam int N_IN   = 3;
  localparam int N_CLS  = 2;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 40;
  localparam int L      = N_IN * (N_CLS + 1) + N_CLS;
  localparam int LAT    = N_IN * N_CLS + N_CLS;

  typedef logic [DATA_W-1:0] word_arr_t [L];

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              start    = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [0:0]        class_idx;
  logic [N_CLS-1:0]  class_onehot;
  logic [DATA_W-1:0] max_score;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int                m_phase  = 0;
  int                m_count  = 0;
  logic              m_done   = 1'b0;
  int                m_idx    = 0;
  logic [N_CLS-1:0]  m_onehot = '0;
  logic [DATA_W-1:0] m_ms     = '0;
  logic [DATA_W-1:0] m_words [$];

  fc_classifier_fx #(
    .N_IN(N_IN), .N_CLS(N_CLS), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .busy(busy),
    .done(done),
    .class_idx(class_idx),
    .class_onehot(class_onehot),
    .max_score(max_score)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sx(input logic [DATA_W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: evaluate every score from the collected stream, then pick the first maximum.
  function automatic void modelResult(output int idx, output logic [DATA_W-1:0] ms);
    longint sc [N_CLS];
    longint t;
    for (int j = 0; j < N_CLS; j++) begin
      t = 0;
      for (int i = 0; i < N_IN; i++) begin
        t += sx(m_words[i]) * sx(m_words[N_IN + i * N_CLS + j]);
      end
      t += sx(m_words[N_IN * (N_CLS + 1) + j]) * (longint'(1) << FRAC_W);
      t = t >>> FRAC_W;
      if (t > 32767)  t = 32767;
      if (t < -32768) t = -32768;
      sc[j] = t;
    end
    idx = 0;
    for (int j = 1; j < N_CLS; j++) begin
      if (sc[j] > sc[idx]) idx = j;
    end
    ms = DATA_W'(sc[idx]);
  endfunction

  // Transaction-level model: counts accepted words and edges since the last word.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  = 0;
      m_count  = 0;
      m_done   = 1'b0;
      m_idx    = 0;
      m_onehot = '0;
      m_ms     = '0;
      m_words.delete();
    end else begin
      cyc++;
      m_done = 1'b0;
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_words.delete();
        end
        1: if (in_valid) begin
          m_words.push_back(in_data);
          if (m_words.size() == L) begin
            m_phase = 2;
            m_count = 0;
          end
        end
        2: begin
          m_count++;
          if (m_count == LAT) begin
            modelResult(m_idx, m_ms);
            m_onehot = N_CLS'(1) << m_idx;
            m_phase  = 3;
            m_done   = 1'b1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("cyc_done", done, m_done);
      checkOutput("cyc_busy", busy, m_phase != 0);
      checkOutput("cyc_in_ready", in_ready, m_phase == 1);
      checkOutput("cyc_class_idx", class_idx, m_idx);
      checkOutput("cyc_class_onehot", class_onehot, m_onehot);
      checkOutput("cyc_max_score", max_score, m_ms);
    end
  end

  // Runs one inference from an IDLE negedge and returns at the negedge where done is high.
  task automatic applyStimulus(input word_arr_t words, input int max_gap, input bit noisy,
                               output int latency);
    int last;
    int waited;
    int gap;
    latency  = -1;
    start    = 1'b1;
    in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    in_data  = DATA_W'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < L; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = words[k];
      start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    last     = cyc;
    waited   = 0;
    while (done !== 1'b1 && waited < 40) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = DATA_W'($urandom);
        start    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (done !== 1'b1) checkOutput("done_timeout", done, 1);
    else latency = cyc - last;
  endtask

  task automatic pinResult(input string name, input int idx, input logic [DATA_W-1:0] ms);
    checkOutput({name, "_class_idx"}, class_idx, idx);
    checkOutput({name, "_class_onehot"}, class_onehot, N_CLS'(1) << idx);
    checkOutput({name, "_max_score"}, max_score, ms);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    word_arr_t nom, tie, sat_pos, sat_neg, rnd;
    int lat;
    int v;

    nom     = '{16'h0100, 16'h0200, 16'hFF00,
                16'h0100, 16'h0080, 16'h0080, 16'h0100, 16'h0100, 16'hFF00,
                16'h0040, 16'hFF80};
    tie     = '{16'h0100, 16'h0200, 16'hFF00,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0100, 16'h0100};
    sat_pos = '{16'h7FFF, 16'h7FFF, 16'h7FFF,
                16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                16'h0000, 16'h0000};
    sat_neg = '{16'h7FFF, 16'h7FFF, 16'h7FFF,
                16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                16'h0000, 16'h0000};

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_onehot", class_onehot, 0);
    checkOutput("rst_max_score", max_score, 0);
    #2 reset = 1'b0;
    @(negedge clk);

    $display("[TB] nominal");
    applyStimulus(nom, 0, 1'b0, lat);
    checkOutput("nom_latency", lat, 8);
    pinResult("nom", 1, 16'h0300);
    checkOutput("nom_model_ms", m_ms, 16'h0300);
    @(negedge clk);
    checkOutput("nom_done_width", done, 0);
    checkOutput("nom_hold", max_score, 16'h0300);

    $display("[TB] tie, back-to-back");
    applyStimulus(tie, 0, 1'b0, lat);
    pinResult("tie", 0, 16'h0100);
    @(negedge clk);

    $display("[TB] saturation");
    applyStimulus(sat_pos, 1, 1'b0, lat);
    pinResult("sat_pos", 0, 16'h7FFF);
    @(negedge clk);
    applyStimulus(sat_neg, 1, 1'b0, lat);
    pinResult("sat_neg", 0, 16'h8000);
    @(negedge clk);

    $display("[TB] backpressure and protocol noise");
    applyStimulus(nom, 3, 1'b1, lat);
    checkOutput("bp_latency", lat, 8);
    pinResult("bp", 1, 16'h0300);
    @(negedge clk);

    $display("[TB] reset mid-MAC");
    applyStimulus(tie, 0, 1'b0, lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < L; k++) begin
      in_valid = 1'b1;
      in_data  = nom[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_onehot", class_onehot, 0);
    checkOutput("mid_rst_max_score", max_score, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    applyStimulus(nom, 0, 1'b0, lat);
    pinResult("post_rst", 1, 16'h0300);
    @(negedge clk);

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < L; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          rnd[k] = DATA_W'($urandom);
        end else begin
          v      = int'($urandom_range(0, 2047)) - 1024;
          rnd[k] = DATA_W'(v);
        end
      end
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = DATA_W'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      applyStimulus(rnd, 3, 1'b1, lat);
      checkOutput("rnd_latency", lat, 8);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
